// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg: constants, drain FSM states and width helpers shared by NTT blocks.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ntt_pkg;

  localparam int NTT_LOG_N          = 12;
  localparam int NTT_COEFF_W        = 30;
  localparam int NTT_LOG_CORE_COUNT = 5;
  localparam int NTT_ADDR_W         = 9;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_t;

  // Tag carries {address, core index, bank bit}.
  function automatic int ntt_tag_width(input int log_core_count);
    return NTT_ADDR_W + log_core_count + 1;
  endfunction

  function automatic int ntt_log_beats(input int log_n, input int log_core_count);
    return log_n - 2 - log_core_count;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_output_drain_if.sv
// ---------------------------------------------------------------------------
// ntt_output_drain_if: router beat input and serialized word output streams.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ntt_output_drain_if
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = NTT_LOG_CORE_COUNT,
  parameter int COEFF_W        = NTT_COEFF_W
);

  localparam int CORES  = 1 << LOG_CORE_COUNT;
  localparam int WORD_W = 2 * COEFF_W;
  localparam int TAG_W  = ntt_tag_width(LOG_CORE_COUNT);

  logic                                in_valid;
  logic [CORES-1:0][1:0][WORD_W-1:0]   in_data;
  logic [NTT_ADDR_W-1:0]               in_address;
  logic                                in_ready;

  logic                                out_valid;
  logic                                out_ready;
  logic [WORD_W-1:0]                   out_data;
  logic [TAG_W-1:0]                    out_tag;
  logic                                out_last;

  modport master (
    output in_valid, in_data, in_address, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_last
  );

  modport slave (
    input  in_valid, in_data, in_address, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_last
  );

endinterface

`default_nettype wire

// File: rtl/ntt_drain_slot.sv
// ---------------------------------------------------------------------------
// ntt_drain_slot: one beat store (word array, address, FULL flag).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_drain_slot
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = NTT_LOG_CORE_COUNT,
  parameter int COEFF_W        = NTT_COEFF_W
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   wr_en,
  input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_W-1:0]      wr_data,
  input  logic [NTT_ADDR_W-1:0]                                  wr_address,
  input  logic                                                   clr,
  input  logic [LOG_CORE_COUNT:0]                                rd_index,
  output logic                                                   full,
  output logic [2*COEFF_W-1:0]                                   rd_word,
  output logic [NTT_ADDR_W-1:0]                                  address
);

  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_W-1:0] data;

  // Payload is left unreset; FULL alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data    <= wr_data;
      address <= wr_address;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

  // rd_index = {core, bank}: core is the outer drain order, bank the inner.
  assign rd_word = data[rd_index[LOG_CORE_COUNT:1]][rd_index[0]];

endmodule

`default_nettype wire

// File: rtl/ntt_output_drain.sv
// ---------------------------------------------------------------------------
// ntt_output_drain: ping-pong buffer serialising router beats into tagged words.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_output_drain
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = NTT_LOG_CORE_COUNT,
  parameter int LOG_N          = NTT_LOG_N,
  parameter int COEFF_W        = NTT_COEFF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ntt_output_drain_if.slave    bus,
  output logic                 overflow
);

  localparam int WORD_W    = 2 * COEFF_W;
  localparam int IDX_W     = LOG_CORE_COUNT + 1;
  localparam int LOG_BEATS = ntt_log_beats(LOG_N, LOG_CORE_COUNT);
  localparam int BEAT_W    = (LOG_BEATS > 0) ? LOG_BEATS : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((1 << LOG_BEATS) - 1);

  drain_state_t      state, state_nx;
  logic              wr_ptr;
  logic              rd_ptr, rd_ptr_nx;
  logic [IDX_W-1:0]  word_idx, word_idx_nx;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nx;

  logic [1:0]            slot_full;
  logic [WORD_W-1:0]     slot_word [2];
  logic [NTT_ADDR_W-1:0] slot_addr [2];

  logic in_ready;
  logic accept;
  logic out_valid;
  logic handshake;
  logic final_word;
  logic final_hs;

  assign in_ready   = ~(slot_full[0] & slot_full[1]);
  assign accept     = bus.in_valid & in_ready;
  assign out_valid  = (state == ST_DRAIN);
  assign handshake  = out_valid & bus.out_ready;
  assign final_word = (word_idx == LAST_IDX);
  assign final_hs   = handshake & final_word;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_slot
      localparam logic SEL = 1'(i);

      ntt_drain_slot #(
        .LOG_CORE_COUNT (LOG_CORE_COUNT),
        .COEFF_W        (COEFF_W)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (accept && (wr_ptr == SEL)),
        .wr_data    (bus.in_data),
        .wr_address (bus.in_address),
        .clr        (final_hs && (rd_ptr == SEL)),
        .rd_index   (word_idx),
        .full       (slot_full[i]),
        .rd_word    (slot_word[i]),
        .address    (slot_addr[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      word_idx <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_ptr   <= rd_ptr_nx;
      word_idx <= word_idx_nx;
      beat_cnt <= beat_cnt_nx;
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (bus.in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    rd_ptr_nx   = rd_ptr;
    word_idx_nx = word_idx;
    beat_cnt_nx = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (slot_full[rd_ptr]) begin
          state_nx    = ST_DRAIN;
          word_idx_nx = '0;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          if (final_word) begin
            word_idx_nx = '0;
            rd_ptr_nx   = ~rd_ptr;
            beat_cnt_nx = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
            // Chain straight into the other slot when it is already loaded.
            if (!slot_full[~rd_ptr]) begin
              state_nx = ST_IDLE;
            end
          end else begin
            word_idx_nx = word_idx + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? slot_word[rd_ptr] : '0;
  assign bus.out_tag   = out_valid ? {slot_addr[rd_ptr], word_idx} : '0;
  assign bus.out_last  = out_valid & final_word & (beat_cnt == LAST_BEAT);

endmodule

`default_nettype wire

// File: tb/tb_ntt_output_drain.sv
// ---------------------------------------------------------------------------
// tb_ntt_output_drain: directed + randomized bench against a word-queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ntt_output_drain;
  import ntt_pkg::*;

  localparam int LCC   = 5;
  localparam int CORES = 1 << LCC;
  localparam int BEATS = 32;
  localparam int W     = 60;
  localparam int TW    = 9 + LCC + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic overflow;

  ntt_output_drain_if #(.LOG_CORE_COUNT(LCC), .COEFF_W(30)) bus ();

  ntt_output_drain #(
    .LOG_CORE_COUNT (LCC),
    .LOG_N          (12),
    .COEFF_W        (30)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          last;
    logic          fin;
  } exp_t;

  exp_t q[$];
  int   beats_q;
  int   acc_count;
  bit   hold;
  bit   ovf_exp;
  int   compared;
  int   mismatched;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    beats_q   = 0;
    acc_count = 0;
    hold      = 1'b0;
    ovf_exp   = 1'b0;
  endtask

  task automatic push_beat();
    exp_t e;
    for (int k = 0; k < CORES; k++) begin
      for (int j = 0; j < 2; j++) begin
        e.data = bus.in_data[k][j];
        e.tag  = {bus.in_address, LCC'(k), 1'(j)};
        e.fin  = (k == CORES - 1) && (j == 1);
        e.last = e.fin && ((acc_count % BEATS) == BEATS - 1);
        q.push_back(e);
      end
    end
    acc_count++;
    beats_q++;
  endtask

  task automatic set_random_beat();
    bus.in_address = 9'($urandom);
    for (int k = 0; k < CORES; k++) begin
      for (int j = 0; j < 2; j++) begin
        bus.in_data[k][j] = W'({$urandom(), $urandom()});
      end
    end
  endtask

  task automatic set_pattern_beat(input logic [8:0] addr);
    bus.in_address = addr;
    for (int k = 0; k < CORES; k++) begin
      for (int j = 0; j < 2; j++) begin
        bus.in_data[k][j] = {30'(k * 2 + j + 1), 30'(k * 2 + j)};
      end
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit exp_valid, exp_rdy, hs, acc, drop;
    @(negedge clk);
    exp_rdy   = (beats_q < 2);
    exp_valid = (q.size() > 0) && !hold;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("overflow", 64'(overflow), 64'(ovf_exp));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0].data));
      chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
      chk("out_last", 64'(bus.out_last), 64'(q[0].last));
    end
    hs   = exp_valid && bus.out_ready;
    acc  = bus.in_valid && exp_rdy;
    drop = bus.in_valid && !exp_rdy;
    @(posedge clk);
    if (hs) begin
      if (q[0].fin) beats_q--;
      void'(q.pop_front());
    end
    if (drop) ovf_exp = 1'b1;
    hold = 1'b0;
    if (acc) begin
      // A beat landing on an empty pipeline waits one cycle for the drain to start.
      if (q.size() == 0) hold = 1'b1;
      push_beat();
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    compared   = 0;
    mismatched = 0;
    reset_model();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_address = '0;
    bus.in_data    = '0;
    #2;
    apply_reset();
    cycle();

    // Single patterned beat at address 5.
    set_pattern_beat(9'd5);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    run(80);

    // Two back-to-back beats.
    set_random_beat();
    bus.in_valid = 1'b1;
    cycle();
    set_random_beat();
    cycle();
    bus.in_valid = 1'b0;
    run(140);

    // Third beat offered while both slots hold data.
    set_random_beat();
    bus.in_valid = 1'b1;
    cycle();
    set_random_beat();
    cycle();
    set_random_beat();
    cycle();
    bus.in_valid = 1'b0;
    run(140);

    // out_ready pattern 1,0,0,1 with random offers.
    for (int i = 0; i < 800; i++) begin
      bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      bus.in_valid  = ($urandom_range(0, 7) == 0);
      if (bus.in_valid) set_random_beat();
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    run(200);

    // Stream 33 beats after a fresh reset to cover the transform boundary.
    apply_reset();
    n = 0;
    while (acc_count < 33 && n < 3000) begin
      bus.in_valid = (beats_q < 2);
      if (bus.in_valid) set_random_beat();
      cycle();
      n++;
    end
    bus.in_valid = 1'b0;
    run(150);

    // Reset while word 20 of a beat is on the output.
    apply_reset();
    cycle();
    set_random_beat();
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    n = 0;
    while (q.size() > 44 && n < 200) begin
      cycle();
      n++;
    end
    apply_reset();
    cycle();
    set_random_beat();
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    run(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ntt_output_drain.md
NTT_OUTPUT_DRAIN -- requirements
Module: ntt_output_drain

Interface
REQ-001 SHALL have parameter LOG_CORE_COUNT, default 5: log2 of the butterfly core count (CORES = 1 << LOG_CORE_COUNT).
REQ-002 SHALL have parameter LOG_N, default 12: log2 of the transform length.
REQ-003 SHALL have parameter COEFF_W, default 30: coefficient width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 in_valid  input  1  a final-phase router beat is present on in_data and in_address.
REQ-007 in_data  input  [CORES][2] x 2*COEFF_W  router final-phase words; each word packs {coeff_hi, coeff_lo}.
REQ-008 in_address  input  9  router output address for the beat.
REQ-009 in_ready  output  1  a free slot exists; a beat is accepted when in_valid && in_ready.
REQ-010 out_valid  output  1  out_data, out_tag and out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the word when out_valid && out_ready.
REQ-012 out_data  output  2*COEFF_W  one serialized word.
REQ-013 out_tag  output  9+LOG_CORE_COUNT+1  {address, core, bank} of out_data.
REQ-014 out_last  output  1  final word of a complete transform.
REQ-015 overflow  output  1  sticky flag: a beat was offered while in_ready was low.

Function
REQ-016 SHALL hold two beat slots (ping-pong), each storing CORES x 2 words plus the address; each slot is EMPTY or FULL.
REQ-017 in_ready SHALL be high exactly when at least one slot is EMPTY; it is a registered function of slot state and does not depend on in_valid in the same cycle.
REQ-018 An accepted beat SHALL be written into the write-pointer slot, which is then marked FULL; the write pointer toggles.
REQ-019 The drain FSM SHALL have states IDLE and DRAIN. In IDLE it enters DRAIN when the read-pointer slot is FULL. In DRAIN it returns to IDLE after the last word of that slot is handed off, unless the other slot is FULL, in which case it stays in DRAIN with no bubble.
REQ-020 Drain order within a slot SHALL be core 0..CORES-1 (outer) and bank 0..1 (inner), giving 2*CORES words per beat.
REQ-021 out_tag SHALL equal {slot address, core index, bank index} of the word on out_data.
REQ-022 A beat accepted at edge t SHALL present word 0 with out_valid high after edge t+1 when the drain is IDLE; each handshake advances to the next word on the following cycle.
REQ-023 While out_valid is high and out_ready is low, out_data, out_tag and out_last SHALL hold stable.
REQ-024 A slot SHALL become EMPTY on the handshake of its final word. A new beat may be accepted into that slot in the same cycle, with in_ready as sampled before that edge.
REQ-025 A beat counter SHALL count fully drained beats modulo BEATS = 1 << (LOG_N-2-LOG_CORE_COUNT), i.e. 32 by default.
REQ-026 out_last SHALL be high only on the final word of the beat with counter value BEATS-1; the counter then wraps to 0.
REQ-027 in_valid while in_ready is low SHALL drop the beat, leave both slots unchanged, and set overflow, which remains set until reset.
REQ-028 A simultaneous accept and final-word handshake on different slots SHALL both take effect in the same edge.

Reset
REQ-029 Assertion of rst_n low SHALL immediately force: both slots EMPTY, both pointers 0, FSM IDLE, word and beat counters 0, out_valid 0, out_last 0, overflow 0, out_data 0, out_tag 0.
REQ-030 in_ready SHALL read 1 on the first edge after rst_n deasserts.
REQ-031 Reset in mid-drain SHALL discard buffered data; no partial beat is resumed.
REQ-032 Slot data storage is not required to be reset.

Structure
REQ-033 LOG_N, COEFF_W, the default LOG_CORE_COUNT, and the tag-width function SHALL live in shared package ntt_pkg, which the router also uses.
REQ-034 The single slot store (data array, address, FULL bit) SHALL be sub-module ntt_drain_slot, instantiated twice.

Verification
REQ-035 Reset, then one beat with in_data[k][j] = {k*2+j+1, k*2+j}, address 5, out_ready=1 -> 64 consecutive words, tag {5,k,j}, in order, word 0 one cycle after accept, out_last=0.
REQ-036 Two beats on consecutive cycles with out_ready=1 -> 128 back-to-back words with no bubble between the beats; in_ready low from the cycle after the second accept until word 63 hands off.
REQ-037 Third beat offered while both slots are FULL -> beat dropped, overflow=1 and held, and the next 128 words are from beats 1 and 2 only.
REQ-038 out_ready toggled 1,0,0,1 repeatedly -> outputs stable during stalls and no word lost or duplicated (scoreboard).
REQ-039 32 beats streamed -> out_last high only on word 2047, tag {addr31,31,1}; beat 33 -> out_last low again.
REQ-040 rst_n pulsed low during word 20 of a drain -> out_valid low asynchronously, in_ready=1 after release, and the following beat drains from word 0.
